man_div: RTL and testbench

//  Iterative restoring divider for 7-bit FP mantissas (hidden 1 implied). Computes 1.Xm / 1.Ym.

---
 rtl/man_div_pkg.sv | 16 +
 rtl/man_div_step.sv | 27 ++
 rtl/man_div.sv | 123 ++++++++++++
 tb/tb_man_div.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/man_div_pkg.sv
// rtl/man_div_pkg.sv - shared constants and state encoding for the mantissa divider
//
// Purpose: mantissa width, quotient bit count, iteration counter width and the
//          FSM state type used by man_div.
package man_div_pkg;

  localparam int MW    = 7;            // mantissa width excluding hidden 1
  localparam int NIT   = MW + 2;       // quotient bits: 1 integer + MW+1 fraction
  localparam int CNT_W = $clog2(NIT);  // iteration counter width

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/man_div_step.sv
// rtl/man_div_step.sv - one combinational restoring-division step
//
// Purpose: compare partial remainder against divisor, subtract when it fits,
//          emit the quotient bit and the shifted remainder for the next step.
// Ports:
//   rem_i       partial remainder (MW+2 bits, always < 2*div)
//   div_i       divisor with hidden 1 (MW+1 bits)
//   rem_next_o  remainder after optional subtract, shifted left by one
//   q_bit_o     quotient bit produced by this step
module man_div_step #(
  parameter int MW = 7
) (
  input  logic [MW+1:0] rem_i,
  input  logic [MW:0]   div_i,
  output logic [MW+1:0] rem_next_o,
  output logic          q_bit_o
);

  logic [MW:0] diff;

  // When the subtract happens the result is below div, so MW+1 bits suffice
  // and the modulo wrap of the narrow subtract gives the exact value.
  assign diff       = rem_i[MW:0] - div_i;
  assign q_bit_o    = (rem_i >= {1'b0, div_i});
  assign rem_next_o = q_bit_o ? {diff, 1'b0} : {rem_i[MW:0], 1'b0};

endmodule

// File: rtl/man_div.sv
// rtl/man_div.sv - iterative restoring divider for FP mantissas (1.Xm / 1.Ym)
//
// Purpose: one quotient bit per clock, NIT steps, then normalize and truncate.
// Ports:
//   clk     clock, rising edge
//   rst_n   synchronous reset, active-low
//   start   request, accepted only while busy=0
//   Xm, Ym  dividend / divisor mantissas, captured with start
//   busy    division in progress
//   done    one-cycle pulse, results valid
//   Zm      normalized quotient fraction bits (truncated)
//   qlt1    quotient < 1, exponent must be decremented
//   sticky  inexact: discarded quotient bit or nonzero remainder
module man_div
  import man_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [MW-1:0] Xm,
  input  logic [MW-1:0] Ym,
  output logic          busy,
  output logic          done,
  output logic [MW-1:0] Zm,
  output logic          qlt1,
  output logic          sticky
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MW+1:0]    rem_q;
  logic [MW:0]      div_q;
  logic [NIT-2:0]   q_q;      // top quotient bit is only needed in q_d
  logic             busy_q;
  logic             done_q;
  logic [MW-1:0]    zm_q;
  logic             qlt1_q;
  logic             sticky_q;

  logic [MW+1:0]    rem_d;
  logic             q_bit;
  logic [NIT-1:0]   q_d;
  logic [MW-1:0]    zm_d;
  logic             qlt1_d;
  logic             sticky_d;
  logic             last_step;

  man_div_step #(.MW(MW)) u_step (
    .rem_i      (rem_q),
    .div_i      (div_q),
    .rem_next_o (rem_d),
    .q_bit_o    (q_bit)
  );

  assign q_d       = {q_q, q_bit};
  assign last_step = (cnt_q == CNT_W'(NIT - 1));

  // Quotient lies in (0.5, 2): either the integer bit is set, or the first
  // fraction bit is, in which case the result is shifted up by one.
  always_comb begin
    zm_d     = '0;
    qlt1_d   = 1'b0;
    sticky_d = 1'b0;
    if (q_d[NIT-1]) begin
      zm_d     = q_d[NIT-2:1];
      sticky_d = q_d[0] | (rem_d != '0);
    end else begin
      zm_d     = q_d[NIT-3:0];
      qlt1_d   = 1'b1;
      sticky_d = (rem_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      q_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zm_q     <= '0;
      qlt1_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q   <= {2'b01, Xm};
            div_q   <= {1'b1, Ym};
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          q_q   <= q_d[NIT-2:0];
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            zm_q     <= zm_d;
            qlt1_q   <= qlt1_d;
            sticky_q <= sticky_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Zm     = zm_q;
  assign qlt1   = qlt1_q;
  assign sticky = sticky_q;

endmodule

// File: tb/tb_man_div.sv
// tb/tb_man_div.sv - scoreboard bench for man_div
module tb_man_div;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] Xm, Ym;
  logic       busy, done, qlt1, sticky;
  logic [6:0] Zm;

  man_div dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Xm(Xm), .Ym(Ym),
    .busy(busy), .done(done), .Zm(Zm), .qlt1(qlt1), .sticky(sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] zm;
    logic       ql;
    logic       st;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] z, input logic q, input logic s);
    exp_t e;
    e.zm = z; e.ql = q; e.st = s; e.cyc = 0;
    return e;
  endfunction

  // Reference: quotient with 8 fraction bits is floor(A*256/B), A=1.X, B=1.Y scaled by 128.
  function automatic exp_t model(input logic [6:0] x, input logic [6:0] y);
    exp_t e;
    int a, b, q, r;
    a = 128 + int'(x);
    b = 128 + int'(y);
    q = (a * 256) / b;
    r = (a * 256) % b;
    if (q >= 256) begin
      e.zm = 7'((q >> 1) & 127);
      e.ql = 1'b0;
      e.st = ((q & 1) != 0) || (r != 0);
    end else begin
      e.zm = 7'(q & 127);
      e.ql = 1'b1;
      e.st = (r != 0);
    end
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("Zm", 32'(Zm), 32'(e.zm));
        check("qlt1", 32'(qlt1), 32'(e.ql));
        check("sticky", 32'(sticky), 32'(e.st));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  // Called at a negedge with busy=0; returns one negedge later.
  task automatic issue(input logic [6:0] x, input logic [6:0] y, input exp_t e_in);
    exp_t e;
    wait_idle();
    e = e_in;
    e.cyc = cyc + 10;
    sb.push_back(e);
    Xm = x; Ym = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Xm = 7'($urandom);
    Ym = 7'($urandom);
  endtask

  function automatic logic [6:0] pick();
    case ($urandom % 5)
      0:       return 7'h00;
      1:       return 7'h7F;
      default: return 7'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [6:0] x, y;
    rst_n = 1'b0; start = 1'b0; Xm = '0; Ym = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_Zm", 32'(Zm), 32'd0);
    check("rst_qlt1", 32'(qlt1), 32'd0);
    check("rst_sticky", 32'(sticky), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(7'h00, 7'h00, mk(7'h00, 1'b0, 1'b0));
    issue(7'h00, 7'h40, mk(7'h2A, 1'b1, 1'b1));
    issue(7'h7F, 7'h00, mk(7'h7F, 1'b0, 1'b0));
    issue(7'h00, 7'h7F, mk(7'h00, 1'b1, 1'b1));

    // Starts while busy (cycles 3, 5 and the final RUN cycle) must be ignored.
    wait_idle();
    issue(7'h11, 7'h22, model(7'h11, 7'h22));
    repeat (2) @(negedge clk);
    start = 1'b1; Xm = 7'h55; Ym = 7'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; Xm = 7'h3C; Ym = 7'h70;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; Xm = 7'h7F; Ym = 7'h7F;
    check("busy_last_run", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("done_cycle", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    issue(7'h6B, 7'h19, model(7'h6B, 7'h19));

    // Reset on the 4th RUN cycle aborts without a done pulse.
    wait_idle();
    issue(7'h2D, 7'h5E, model(7'h2D, 7'h5E));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_Zm", 32'(Zm), 32'd0);
    check("abort_sticky", 32'(sticky), 32'd0);
    repeat (12) @(negedge clk);
    issue(7'h40, 7'h00, model(7'h40, 7'h00));

    for (int i = 0; i < 40; i++) begin
      x = pick();
      y = pick();
      if (($urandom % 3) == 0 && busy) begin
        wait_done();
        issue(x, y, model(x, y));
      end else begin
        issue(x, y, model(x, y));
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
